div_unit: RTL

- Multi-cycle 32-bit integer divider serving the EX stage for DIV/DIVU.
- Produces {remainder, quotient} for the HI/LO write path.
- Generates the EX-stage stall request consumed by the pipeline stall controller, which freezes PC/IF/ID/EX while a divide is in flight.
- Uses a radix-2 restoring algorithm: one quotient bit per cycle, plus a fast path for divide-by-zero.

---
 rtl/div_unit_if.sv | 25 ++
 rtl/div_unit.sv | 126 ++++++++++++
 2 files changed

// File: rtl/div_unit_if.sv
// Divider request/response bundle between the EX stage and div_unit.
interface div_unit_if #(
    parameter int unsigned DATA_W = 32
);
    logic                  signed_div_i;
    logic [DATA_W-1:0]     opdata1_i;
    logic [DATA_W-1:0]     opdata2_i;
    logic                  start_i;
    logic                  annul_i;
    logic [2*DATA_W-1:0]   result_o;
    logic                  ready_o;
    logic                  stallreq_o;

    // EX stage side: issues requests, consumes results and the stall request.
    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o, stallreq_o
    );

    // Divider side.
    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o, stallreq_o
    );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU.
// Result is {remainder, quotient}; a divide-by-zero short-cuts to a zero result.
module div_unit #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 6
) (
    input logic       clk,
    input logic       rst,
    div_unit_if.slave bus
);

    typedef enum logic [1:0] {StFree, StByZero, StOn, StEnd} state_e;

    state_e                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [DATA_W-1:0]     rem_q;   // partial remainder
    logic [DATA_W-1:0]     dvd_q;   // dividend bits shift out, quotient bits shift in
    logic [DATA_W-1:0]     dvs_q;   // divisor magnitude
    logic                  q_neg_q;
    logic                  r_neg_q;
    logic [2*DATA_W-1:0]   result_q;
    logic                  ready_q;

    logic [DATA_W:0]       trial;
    logic                  qbit;
    logic [DATA_W-1:0]     rem_d;
    logic [DATA_W-1:0]     dvd_d;
    logic [DATA_W-1:0]     quo_fix;
    logic [DATA_W-1:0]     rem_fix;
    logic [DATA_W-1:0]     abs_a;
    logic [DATA_W-1:0]     abs_b;

    // One restoring step plus operand magnitudes and final sign fix-up.
    always_comb begin
        // Extra top bit: the shifted remainder can exceed DATA_W bits for large divisors.
        trial   = {rem_q, dvd_q[DATA_W-1]} - {1'b0, dvs_q};
        qbit    = ~trial[DATA_W];
        rem_d   = qbit ? trial[DATA_W-1:0] : {rem_q[DATA_W-2:0], dvd_q[DATA_W-1]};
        dvd_d   = {dvd_q[DATA_W-2:0], qbit};
        quo_fix = q_neg_q ? -dvd_d : dvd_d;
        rem_fix = r_neg_q ? -rem_d : rem_d;
        abs_a   = (bus.signed_div_i && bus.opdata1_i[DATA_W-1]) ? -bus.opdata1_i
                                                                : bus.opdata1_i;
        abs_b   = (bus.signed_div_i && bus.opdata2_i[DATA_W-1]) ? -bus.opdata2_i
                                                                : bus.opdata2_i;
    end

    // Control FSM with datapath registers and registered result/ready.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StFree;
            cnt_q    <= '0;
            rem_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StFree: begin
                    ready_q  <= 1'b0;
                    result_q <= '0;
                    if (bus.start_i && !bus.annul_i) begin
                        if (bus.opdata2_i == '0) begin
                            state_q <= StByZero;
                        end else begin
                            dvd_q   <= abs_a;
                            dvs_q   <= abs_b;
                            rem_q   <= '0;
                            cnt_q   <= '0;
                            q_neg_q <= bus.signed_div_i &
                                       (bus.opdata1_i[DATA_W-1] ^ bus.opdata2_i[DATA_W-1]);
                            r_neg_q <= bus.signed_div_i & bus.opdata1_i[DATA_W-1];
                            state_q <= StOn;
                        end
                    end
                end
                StByZero: begin
                    result_q <= '0;
                    if (bus.annul_i) begin
                        ready_q <= 1'b0;
                        state_q <= StFree;
                    end else begin
                        ready_q <= 1'b1;
                        state_q <= StEnd;
                    end
                end
                StOn: begin
                    if (bus.annul_i) begin
                        ready_q  <= 1'b0;
                        result_q <= '0;
                        state_q  <= StFree;
                    end else begin
                        rem_q <= rem_d;
                        dvd_q <= dvd_d;
                        cnt_q <= cnt_q + CNT_W'(1);
                        // Last quotient bit: publish the sign-corrected result.
                        if (cnt_q == CNT_W'(DATA_W - 1)) begin
                            result_q <= {rem_fix, quo_fix};
                            ready_q  <= 1'b1;
                            state_q  <= StEnd;
                        end
                    end
                end
                StEnd: begin
                    if (bus.annul_i || !bus.start_i) begin
                        ready_q  <= 1'b0;
                        result_q <= '0;
                        state_q  <= StFree;
                    end
                end
                default: state_q <= StFree;
            endcase
        end
    end

    // Stall the pipeline while a request is pending and no result is presented yet.
    always_comb begin
        bus.stallreq_o = bus.start_i && !bus.annul_i && (state_q != StEnd);
        bus.result_o   = result_q;
        bus.ready_o    = ready_q;
    end

endmodule
